// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry saturating
// direction counters.
//
// The fetch PC is looked up combinationally. Resolved branches from execute
// are written back at the rising clock edge, and flush clears every valid bit.
//
// Optional build macro: BTB_BYPASS_EN. When it is defined, an update to the
// exact PC being fetched in the same cycle is forwarded to the lookup outputs.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; clears all entry state
//   fetch_pc       PC looked up this cycle
//   predict_hit    valid entry whose tag matches fetch_pc
//   predict_taken  hit and counter MSB set
//   predict_target stored target on hit, otherwise 0
//   update_en      resolved branch outcome present this cycle
//   update_pc      PC of the resolved branch
//   update_taken   actual direction of the resolved branch
//   update_target  actual target of the resolved branch
//   flush          clear all valid bits at the next edge
module btb_predictor #(
    parameter int PC_WIDTH = 16,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    output logic                predict_hit,
    output logic                predict_taken,
    output logic [PC_WIDTH-1:0] predict_target,
    input  logic                update_en,
    input  logic [PC_WIDTH-1:0] update_pc,
    input  logic                update_taken,
    input  logic [PC_WIDTH-1:0] update_target,
    input  logic                flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CTR_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX_W-1:0]    fetch_idx;
    logic [TAG_W-1:0]    fetch_tag;
    logic                stored_hit;

    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic                upd_write;
    logic [CTR_BITS-1:0] upd_ctr;
    logic [PC_WIDTH-1:0] upd_target;

    assign fetch_idx  = fetch_pc[IDX_W-1:0];
    assign fetch_tag  = fetch_pc[PC_WIDTH-1:IDX_W];
    assign stored_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // Post-update contents of the entry addressed by update_pc. A miss that
    // resolves not-taken does not allocate, so it produces no write at all.
    assign upd_idx   = update_pc[IDX_W-1:0];
    assign upd_tag   = update_pc[PC_WIDTH-1:IDX_W];
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_write = update_en && (upd_hit || update_taken);

    always_comb begin
        upd_ctr    = CTR_WEAK;
        upd_target = update_target;
        if (upd_hit) begin
            if (update_taken) begin
                upd_ctr = sat_inc(ctr_q[upd_idx]);
            end else begin
                upd_ctr    = sat_dec(ctr_q[upd_idx]);
                upd_target = target_q[upd_idx];
            end
        end
    end

    always_comb begin
        predict_hit    = stored_hit;
        predict_taken  = stored_hit && ctr_q[fetch_idx][CTR_BITS-1];
        predict_target = stored_hit ? target_q[fetch_idx] : '0;
`ifdef BTB_BYPASS_EN
        // Same-PC forwarding; an edge that flushes or resets discards the
        // update, so nothing is forwarded then.
        if (upd_write && !flush && !reset && (update_pc == fetch_pc)) begin
            predict_hit    = 1'b1;
            predict_taken  = upd_ctr[CTR_BITS-1];
            predict_target = upd_target;
        end
`endif
    end

    // Reset wins over flush, flush wins over update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_write) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= upd_ctr;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed checks for the documented
// scenarios plus randomized traffic compared every cycle against a
// table-of-integers model of the buffer.
module tb_btb_predictor;

    localparam int PC_WIDTH = 16;
    localparam int ENTRIES  = 16;
    localparam int CTR_BITS = 2;
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int CWEAK    = 1 << (CTR_BITS - 1);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [PC_WIDTH-1:0] fetch_pc = '0;
    logic                predict_hit;
    logic                predict_taken;
    logic [PC_WIDTH-1:0] predict_target;
    logic                update_en = 1'b0;
    logic [PC_WIDTH-1:0] update_pc = '0;
    logic                update_taken = 1'b0;
    logic [PC_WIDTH-1:0] update_target = '0;
    logic                flush = 1'b0;

    int  total = 0;
    int  bad   = 0;
    bit  started = 1'b0;

    bit  m_valid [ENTRIES];
    int  m_tag   [ENTRIES];
    int  m_tgt   [ENTRIES];
    int  m_ctr   [ENTRIES];

    btb_predictor #(
        .PC_WIDTH(PC_WIDTH),
        .ENTRIES (ENTRIES),
        .CTR_BITS(CTR_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .predict_hit   (predict_hit),
        .predict_taken (predict_taken),
        .predict_target(predict_target),
        .update_en     (update_en),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Result of resolving branch pc against the model table: whether the entry
    // is written and, if so, its new counter and target.
    function automatic void model_resolve(input int pc, input bit tk, input int tg,
                                          output bit wr, output int nc, output int nt);
        int i = pc % ENTRIES;
        int t = pc / ENTRIES;
        bit h = m_valid[i] && (m_tag[i] == t);
        wr = 1'b0;
        nc = 0;
        nt = 0;
        if (h) begin
            wr = 1'b1;
            nc = tk ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            nt = tk ? tg : m_tgt[i];
        end else if (tk) begin
            wr = 1'b1;
            nc = CWEAK;
            nt = tg;
        end
    endfunction

    // Model state advance at each rising edge.
    always @(posedge clk) begin : model_step
        bit wr;
        int nc;
        int nt;
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 0;
                m_tgt[i]   <= 0;
                m_ctr[i]   <= 0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] <= 1'b0;
        end else if (update_en) begin
            model_resolve(int'(update_pc), update_taken, int'(update_target), wr, nc, nt);
            if (wr) begin
                m_valid[int'(update_pc) % ENTRIES] <= 1'b1;
                m_tag[int'(update_pc) % ENTRIES]   <= int'(update_pc) / ENTRIES;
                m_tgt[int'(update_pc) % ENTRIES]   <= nt;
                m_ctr[int'(update_pc) % ENTRIES]   <= nc;
            end
        end
    end

    // Every-cycle comparison of the lookup outputs against the model.
    always @(negedge clk) begin : compare
        int  i;
        bit  eh;
        bit  et;
        int  etg;
        bit  wr;
        int  nc;
        int  nt;
        if (started) begin
            i   = int'(fetch_pc) % ENTRIES;
            eh  = m_valid[i] && (m_tag[i] == int'(fetch_pc) / ENTRIES);
            et  = eh && (m_ctr[i] >= CWEAK);
            etg = eh ? m_tgt[i] : 0;
`ifdef BTB_BYPASS_EN
            if (update_en && !flush && !reset && (update_pc == fetch_pc)) begin
                model_resolve(int'(update_pc), update_taken, int'(update_target), wr, nc, nt);
                if (wr) begin
                    eh  = 1'b1;
                    et  = (nc >= CWEAK);
                    etg = nt;
                end
            end
`else
            wr = 1'b0;
            nc = 0;
            nt = 0;
`endif
            chk("cyc_hit", {31'b0, predict_hit}, {31'b0, eh});
            chk("cyc_taken", {31'b0, predict_taken}, {31'b0, et});
            chk("cyc_target", {16'b0, predict_target}, etg);
        end
    end

    task automatic cyc(input int fpc, input bit ue, input int upc, input bit ut,
                       input int utg, input bit fl, input bit rs);
        @(posedge clk);
        #1;
        fetch_pc      = fpc[PC_WIDTH-1:0];
        update_en     = ue;
        update_pc     = upc[PC_WIDTH-1:0];
        update_taken  = ut;
        update_target = utg[PC_WIDTH-1:0];
        flush         = fl;
        reset         = rs;
        @(negedge clk);
    endtask

    task automatic fetch(input int pc);
        cyc(pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int pc, input bit tk, input int tg);
        cyc(0, 1, pc, tk, tg, 0, 0);
    endtask

    task automatic expect_lookup(input string name, input bit h, input bit t, input int tg);
        chk({name, "_hit"}, {31'b0, predict_hit}, {31'b0, h});
        chk({name, "_taken"}, {31'b0, predict_taken}, {31'b0, t});
        chk({name, "_target"}, {16'b0, predict_target}, tg);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        started = 1'b1;

        // Reset state
        fetch(16'h0010);
        expect_lookup("reset", 0, 0, 0);

        // Allocation and tag mismatch
        upd(16'h0013, 1, 16'h0040);
        fetch(16'h0013);
        expect_lookup("alloc", 1, 1, 16'h0040);
        chk("alloc_ctr_model", m_ctr[3], 2);
        fetch(16'h0023);
        expect_lookup("tagmiss", 0, 0, 0);

        // Saturation up, down, and recovery
        repeat (3) upd(16'h0013, 1, 16'h0040);
        fetch(16'h0013);
        expect_lookup("sat_hi", 1, 1, 16'h0040);
        chk("sat_hi_ctr_model", m_ctr[3], 3);
        repeat (2) upd(16'h0013, 0, 16'h0999);
        fetch(16'h0013);
        expect_lookup("dec2", 1, 0, 16'h0040);
        chk("dec2_ctr_model", m_ctr[3], 1);
        repeat (2) upd(16'h0013, 0, 16'h0999);
        fetch(16'h0013);
        expect_lookup("sat_lo", 1, 0, 16'h0040);
        chk("sat_lo_ctr_model", m_ctr[3], 0);
        upd(16'h0013, 1, 16'h0040);
        fetch(16'h0013);
        expect_lookup("recover", 1, 0, 16'h0040);

        // Miss not-taken never allocates; taken miss replaces the index
        upd(16'h0055, 0, 16'h0123);
        fetch(16'h0055);
        expect_lookup("nt_miss", 0, 0, 0);
        upd(16'h0023, 1, 16'h0100);
        fetch(16'h0013);
        expect_lookup("replaced", 0, 0, 0);
        fetch(16'h0023);
        expect_lookup("replacer", 1, 1, 16'h0100);

        // Flush discards a same-cycle update
        cyc(0, 1, 16'h0007, 1, 16'h0077, 1, 0);
        fetch(16'h0007);
        expect_lookup("flush_upd", 0, 0, 0);
        fetch(16'h0023);
        expect_lookup("flush_old", 0, 0, 0);

        // Same-cycle update and lookup on a fresh PC
        cyc(16'h0009, 1, 16'h0009, 1, 16'h0200, 0, 0);
`ifdef BTB_BYPASS_EN
        expect_lookup("same_cyc", 1, 1, 16'h0200);
`else
        expect_lookup("same_cyc", 0, 0, 0);
`endif
        fetch(16'h0009);
        expect_lookup("next_cyc", 1, 1, 16'h0200);

        // Reset mid-operation wins over an update
        cyc(16'h0009, 1, 16'h0019, 1, 16'h0300, 0, 1);
        fetch(16'h0009);
        expect_lookup("mid_reset", 0, 0, 0);
        fetch(16'h0019);
        expect_lookup("mid_reset_upd", 0, 0, 0);

        // Randomized traffic over a small PC pool so entries collide and hit
        for (int n = 0; n < 3000; n++) begin
            int upc;
            int fpc;
            upc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 16'hffff))
                                              : int'($urandom_range(0, 63));
            fpc = ($urandom_range(0, 3) == 0) ? upc : int'($urandom_range(0, 63));
            cyc(fpc, bit'($urandom_range(0, 1)), upc, bit'($urandom_range(0, 2) != 0),
                int'($urandom_range(0, 16'hffff)),
                $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
        end

        cyc(0, 0, 0, 0, 0, 0, 0);
        started = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
Parametrised branch target buffer with per-entry saturating direction counters. It is the successor to the core's single-width BTB. The fetch stage looks up the current PC combinationally and receives a hit flag, a predicted direction and a predicted target in the same cycle. The execute stage writes resolved branch outcomes back at the clock edge, and a flush input invalidates the whole table.

Parameters:
PC_WIDTH, 16, width of program counter and target addresses
ENTRIES, 16, number of direct-mapped entries; power of two, minimum 2
CTR_BITS, 2, width of each saturating direction counter; minimum 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
fetch_pc  in  PC_WIDTH  PC being fetched this cycle
predict_hit  out  1  valid entry with matching tag for fetch_pc
predict_taken  out  1  predicted taken (hit and counter MSB set)
predict_target  out  PC_WIDTH  stored target on hit, else 0
update_en  in  1  resolved branch outcome present this cycle
update_pc  in  PC_WIDTH  PC of the resolved branch
update_taken  in  1  actual direction of the resolved branch
update_target  in  PC_WIDTH  actual target of the resolved branch
flush  in  1  invalidate all entries at next edge

Behaviour:
- Derived widths: IDX_W = clog2(ENTRIES); TAG_W = PC_WIDTH - IDX_W.
- Index and tag: index = pc[IDX_W-1:0]; tag = pc[PC_WIDTH-1:IDX_W].
- Entry state: valid (1), tag (TAG_W), target (PC_WIDTH), ctr (CTR_BITS).
- Lookup is purely combinational from current state; zero latency.
  - predict_hit = valid[idx] & (tag[idx] == fetch tag).
  - predict_taken = predict_hit & ctr[idx][CTR_BITS-1].
  - predict_target = predict_hit ? target[idx] : 0.
- Reset: all valid bits, tags, targets and counters cleared to 0. Outputs are then hit=0, taken=0, target=0 for any fetch_pc.
- Update, applied at the rising edge when update_en=1:
  - Hit, taken: ctr increments, saturating at 2^CTR_BITS-1; target <= update_target.
  - Hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate. valid=1, tag and target written, ctr = 2^(CTR_BITS-1), i.e. weakly taken. Any previous entry at that index is replaced.
  - Miss, not taken: no state change; no allocation.
- Flush: at the edge all valid bits clear; tags, targets and counters keep their values.
- Priority at an edge: reset > flush > update. An update in the same cycle as flush or reset is discarded.
- Same-cycle lookup and update to the same index: lookup returns pre-update state, unless BTB_BYPASS_EN is defined.
- Reset asserted mid-operation: takes effect at that edge regardless of other inputs; lookups are all misses from the next cycle.
- There is no other internal state; the block has no stall or handshake inputs.

Optional Feature:
Macro BTB_BYPASS_EN.
- Defined: when update_en=1, flush=0 and update_pc == fetch_pc in the same cycle, the lookup outputs reflect the post-update entry, computed combinationally.
  - A miss, not-taken update still yields no hit.
  - A flush or reset in that cycle disables the bypass.
- Undefined: no forwarding; the lookup always reads registered state only.

Test Plan:
1. Reset, then fetch_pc=0x0010 -> hit=0, taken=0, target=0x0000.
2. Update pc=0x0013, taken=1, target=0x0040; next cycle fetch 0x0013 -> hit=1, taken=1, target=0x0040, ctr=2. Fetch 0x0023 (same index, different tag) -> hit=0.
3. Saturation:
   - Three more taken updates to 0x0013 -> ctr=3.
   - Then two not-taken -> ctr=1, taken=0, hit=1.
   - Then two more not-taken -> ctr=0 with no underflow.
   - Then one taken -> ctr=1, taken=0.
4. Miss, not taken: update pc=0x0055, taken=0 -> fetch 0x0055 gives hit=0. Then update 0x0023 taken target=0x0100 -> replaces the 0x0013 entry; fetch 0x0013 gives hit=0.
5. Flush plus update same cycle (pc=0x0007 taken) -> next cycle fetch 0x0007 and all previously allocated PCs give hit=0.
6. Same-cycle update/lookup on fresh pc 0x0009, taken, target=0x0200:
   - Without BTB_BYPASS_EN -> hit=0 that cycle, hit=1 next cycle.
   - With BTB_BYPASS_EN -> hit=1, taken=1, target=0x0200 that cycle.
